ram32_arbiter: RTL and testbench
================================

RAM32_ARBITER -- requirements
Module: ram32_arbiter

Interface
REQ-001 The block SHALL have parameter RAM_SIZE, default 1024, meaning RAM size in bytes (multiple of 4).
REQ-002 The block SHALL have derived localparam RAM_ADDR_BITS = $clog2(RAM_SIZE/4), meaning the word address width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on posedge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports i_ibus_adr (input, 32, byte address), i_ibus_cyc (input, 1, read request), o_ibus_rdt (output, 32, read data) and o_ibus_ack (output, 1, completion pulse).
REQ-006 The block SHALL have ports i_dbus_adr (input, 32), i_dbus_dat (input, 32, write data), i_dbus_sel (input, 4, byte enables), i_dbus_we (input, 1), i_dbus_cyc (input, 1), o_dbus_rdt (output, 32) and o_dbus_ack (output, 1).
REQ-007 The block SHALL have ports o_ram_addr (output, RAM_ADDR_BITS), o_ram_ce (output, 1), o_ram_we (output, 1), o_ram_wdata (output, 32) and i_ram_rdata (input, 32), driving one word-wide single-port RAM.
- The RAM has 1-cycle read latency: rdata is valid the cycle after ce=1.
- The RAM has no byte enables.

Function
REQ-008 The word address SHALL be adr[RAM_ADDR_BITS+1:2]; adr[1:0] and the upper bits are ignored, so out-of-range addresses wrap.
REQ-009 The FSM SHALL have exactly four states: IDLE, RD, MERGE, ACK.
REQ-010 In IDLE with exactly one cyc high, that port SHALL be granted in the same cycle.
REQ-011 In IDLE with both cyc high, the port not granted last SHALL win (round-robin via a 1-bit last_grant register).
REQ-012 RAM controls SHALL be combinational from the state and the granted port's live inputs; requesters hold adr/dat/sel/we stable while cyc is high.
REQ-013 Read (ibus, or dbus with we=0), cycle T in IDLE: ce=1, we=0 -> RD.
- T+1 (RD): rdt of the granted port <= i_ram_rdata; ack <= 1 -> ACK.
- o_*_ack is high in T+2 only.
REQ-014 Dbus write with sel=4'hF, cycle T in IDLE: ce=1, we=1, wdata=dat; o_dbus_ack <= 1 -> ACK (ack in T+1).
REQ-015 Dbus write with sel not 0 and not F, cycle T in IDLE: ce=1, we=0 -> MERGE.
- T+1 (MERGE): ce=1, we=1; wdata byte k = sel[k] ? dat byte k : i_ram_rdata byte k; ack <= 1 -> ACK.
- Ack is high in T+2.
REQ-016 Dbus write with sel=0 SHALL perform no RAM access and SHALL ack in T+1 via ACK.
REQ-017 ACK SHALL last exactly one cycle and return to IDLE; no grant is made in ACK, and ce=we=0.
REQ-018 ack SHALL be a registered single-cycle pulse, asserted only on the granted port.
REQ-019 o_ibus_rdt SHALL update only on ibus reads and o_dbus_rdt only on dbus reads; both otherwise hold their value, including across writes.
REQ-020 last_grant SHALL update at the grant edge in IDLE.
REQ-021 A granted transaction SHALL complete and ack even if cyc drops before ack.
REQ-022 o_ram_ce and o_ram_we SHALL be 0 in IDLE with no request, and in RD and ACK.
REQ-023 o_ram_addr and o_ram_wdata SHALL be don't-care whenever o_ram_ce=0.
REQ-024 Throughput SHALL be one read per 3 cycles, one full write per 2 cycles and one partial write per 3 cycles.

Reset
REQ-025 While reset=1, the FSM SHALL go to IDLE and o_ram_ce=o_ram_we=0 in that cycle, overriding combinational drive.
REQ-026 Reset SHALL clear o_ibus_ack, o_dbus_ack, o_ibus_rdt and o_dbus_rdt to 0, and set last_grant=dbus so ibus wins the first contention.
REQ-027 Reset mid-transaction SHALL abort it with no ack.
- A MERGE write aborted by reset is not performed; RAM contents are otherwise unchanged.
REQ-028 The first request SHALL be accepted in the first cycle with reset=0.

Verification
REQ-029 Ibus read adr=0x10, RAM word 4 = 0xDEADBEEF -> ce at T, o_ibus_ack in T+2 only, o_ibus_rdt=0xDEADBEEF, o_dbus_ack stays 0.
REQ-030 Dbus write adr=0x8, dat=0x11223344, sel=F, then a dbus read of 0x8 -> ack at T+1; the read returns 0x11223344.
REQ-031 Word 2 = 0xAABBCCDD, dbus write adr=0x8, dat=0x000000EE, sel=4'b0001 -> read then write, ack at T+2; a read-back returns 0xAABBCCEE.
REQ-032 Both cyc held high continuously after reset -> grants alternate ibus, dbus, ibus, ...; acks never overlap.
REQ-033 Reset asserted in MERGE -> no ack, word unchanged, outputs 0; a new request the next cycle completes normally.
REQ-034 Dbus write sel=0 -> ack at T+1 and o_ram_ce never asserted; adr=RAM_SIZE+0x4 accesses word 1 (wrap).

Source files
------------

// File: rtl/ram32_arbiter.sv
// Two-port (ibus/dbus) arbiter onto one word-wide single-port RAM with 1-cycle read latency.
// Partial dbus writes are done as read-modify-write since the RAM has no byte enables.
module ram32_arbiter #(
    parameter int RAM_SIZE = 1024,
    localparam int RAM_ADDR_BITS = $clog2(RAM_SIZE / 4)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              i_ibus_adr,
    input  logic                     i_ibus_cyc,
    output logic [31:0]              o_ibus_rdt,
    output logic                     o_ibus_ack,
    input  logic [31:0]              i_dbus_adr,
    input  logic [31:0]              i_dbus_dat,
    input  logic [3:0]               i_dbus_sel,
    input  logic                     i_dbus_we,
    input  logic                     i_dbus_cyc,
    output logic [31:0]              o_dbus_rdt,
    output logic                     o_dbus_ack,
    output logic [RAM_ADDR_BITS-1:0] o_ram_addr,
    output logic                     o_ram_ce,
    output logic                     o_ram_we,
    output logic [31:0]              o_ram_wdata,
    input  logic [31:0]              i_ram_rdata
);

    typedef enum logic [1:0] {IDLE, RD, MERGE, ACK} state_t;

    state_t      state_q;
    logic        last_grant_q;  // 1 = dbus was granted last
    logic        gnt_dbus_q;
    logic [31:0] ibus_rdt_q;
    logic [31:0] dbus_rdt_q;
    logic        ibus_ack_q;
    logic        dbus_ack_q;

    logic        any_req;
    logic        pick_dbus;
    logic        sel_dbus;
    logic [31:0] adr_mux;

    assign any_req   = i_ibus_cyc | i_dbus_cyc;
    assign pick_dbus = (i_ibus_cyc & i_dbus_cyc) ? ~last_grant_q : i_dbus_cyc;
    assign sel_dbus  = (state_q == IDLE) ? pick_dbus : gnt_dbus_q;
    assign adr_mux   = sel_dbus ? i_dbus_adr : i_ibus_adr;

    always_comb begin
        o_ram_ce    = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = adr_mux[RAM_ADDR_BITS+1:2];
        o_ram_wdata = i_dbus_dat;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    if (!pick_dbus || !i_dbus_we) begin
                        o_ram_ce = 1'b1;
                    end else if (i_dbus_sel == 4'hF) begin
                        o_ram_ce = 1'b1;
                        o_ram_we = 1'b1;
                    end else if (i_dbus_sel != 4'h0) begin
                        o_ram_ce = 1'b1;
                    end
                end
            end
            MERGE: begin
                o_ram_ce = 1'b1;
                o_ram_we = 1'b1;
                for (int unsigned k = 0; k < 4; k++) begin
                    o_ram_wdata[8*k +: 8] = i_dbus_sel[k] ? i_dbus_dat[8*k +: 8]
                                                          : i_ram_rdata[8*k +: 8];
                end
            end
            default: ;
        endcase
        // Reset must win over any live request so an aborted merge never writes.
        if (reset) begin
            o_ram_ce = 1'b0;
            o_ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_dbus_q   <= 1'b0;
            ibus_rdt_q   <= '0;
            dbus_rdt_q   <= '0;
            ibus_ack_q   <= 1'b0;
            dbus_ack_q   <= 1'b0;
        end else begin
            ibus_ack_q <= 1'b0;
            dbus_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        last_grant_q <= pick_dbus;
                        gnt_dbus_q   <= pick_dbus;
                        if (!pick_dbus || !i_dbus_we) begin
                            state_q <= RD;
                        end else if (i_dbus_sel == 4'hF || i_dbus_sel == 4'h0) begin
                            dbus_ack_q <= 1'b1;
                            state_q    <= ACK;
                        end else begin
                            state_q <= MERGE;
                        end
                    end
                end
                RD: begin
                    if (gnt_dbus_q) begin
                        dbus_rdt_q <= i_ram_rdata;
                        dbus_ack_q <= 1'b1;
                    end else begin
                        ibus_rdt_q <= i_ram_rdata;
                        ibus_ack_q <= 1'b1;
                    end
                    state_q <= ACK;
                end
                MERGE: begin
                    dbus_ack_q <= 1'b1;
                    state_q    <= ACK;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ibus_rdt = ibus_rdt_q;
    assign o_dbus_rdt = dbus_rdt_q;
    assign o_ibus_ack = ibus_ack_q;
    assign o_dbus_ack = dbus_ack_q;

    logic unused_ok;
    assign unused_ok = ^{i_ibus_adr[31:RAM_ADDR_BITS+2], i_ibus_adr[1:0],
                         i_dbus_adr[31:RAM_ADDR_BITS+2], i_dbus_adr[1:0]};

endmodule

// File: tb/tb_ram32_arbiter.sv
// Randomized self-checking bench for ram32_arbiter with a RAM model and a word-array reference.
module tb_ram32_arbiter;

    localparam int RAM_SIZE = 1024;
    localparam int WORDS    = RAM_SIZE / 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ibus_adr = '0;
    logic        ibus_cyc = 1'b0;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;
    logic [31:0] dbus_adr = '0;
    logic [31:0] dbus_dat = '0;
    logic [3:0]  dbus_sel = '0;
    logic        dbus_we = 1'b0;
    logic        dbus_cyc = 1'b0;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;
    logic [7:0]  ram_addr;
    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;

    logic [31:0] mem [WORDS];
    logic [31:0] ref_mem [WORDS];
    logic [31:0] exp_irdt, exp_drdt;
    int          errors = 0;
    int          checks = 0;
    int          ce_cnt = 0;

    always #5 clk = ~clk;

    ram32_arbiter #(.RAM_SIZE(RAM_SIZE)) dut (
        .clk(clk), .reset(reset),
        .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
        .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
        .i_dbus_cyc(dbus_cyc), .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack),
        .o_ram_addr(ram_addr), .o_ram_ce(ram_ce), .o_ram_we(ram_we), .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
            ce_cnt <= ce_cnt + 1;
        end
    end

    function automatic int widx(input logic [31:0] adr);
        return int'((adr / 4) % WORDS);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, dat, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (sel[k]) r[8*k +: 8] = dat[8*k +: 8];
        return r;
    endfunction

    // One transaction; cyc dropped after the grant edge, acks observed for 5 cycles.
    task automatic xact(input bit dport, input logic [31:0] adr, dat, input logic [3:0] sel,
                        input bit we, output int lat, output int own, output int other, output int ces);
        int c0;
        lat = 0; own = 0; other = 0;
        @(negedge clk);
        c0 = ce_cnt;
        if (dport) begin
            dbus_adr = adr; dbus_dat = dat; dbus_sel = sel; dbus_we = we; dbus_cyc = 1'b1;
        end else begin
            ibus_adr = adr; ibus_cyc = 1'b1;
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin ibus_cyc = 1'b0; dbus_cyc = 1'b0; end
            if (dport ? dbus_ack : ibus_ack) begin own++; if (lat == 0) lat = k; end
            if (dport ? ibus_ack : dbus_ack) other++;
        end
        ces = ce_cnt - c0;
    endtask

    task automatic test_reset();
        int lat;
        ibus_adr = 32'h40; ibus_cyc = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ram_ce !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL reset_ce_override ce=%b we=%b want 0 0", ram_ce, ram_we); end
        checks++; if (ibus_ack !== 1'b0 || dbus_ack !== 1'b0) begin errors++; $display("FAIL reset_acks i=%b d=%b want 0 0", ibus_ack, dbus_ack); end
        checks++; if (ibus_rdt !== 32'h0 || dbus_rdt !== 32'h0) begin errors++; $display("FAIL reset_rdt i=%h d=%h want 0", ibus_rdt, dbus_rdt); end
        reset = 1'b0;
        #1;
        checks++; if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 8'd16) begin errors++; $display("FAIL first_cycle_grant ce=%b we=%b addr=%0d want 1 0 16", ram_ce, ram_we, ram_addr); end
        lat = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) ibus_cyc = 1'b0;
            if (ibus_ack && lat == 0) lat = k;
        end
        checks++; if (lat != 2) begin errors++; $display("FAIL first_read_latency got=%0d want 2", lat); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (ibus_rdt !== 32'h0 || dbus_rdt !== 32'h0) begin errors++; $display("FAIL reset_clear_rdt i=%h d=%h want 0", ibus_rdt, dbus_rdt); end
        exp_irdt = '0; exp_drdt = '0;
    endtask

    task automatic test_fill();
        int lat, own, oth, ces;
        logic [31:0] d;
        for (int w = 0; w < WORDS; w++) begin
            d = $urandom;
            xact(1'b1, w * 4, d, 4'hF, 1'b1, lat, own, oth, ces);
            ref_mem[w] = d;
            checks++; if (lat != 1 || own != 1 || oth != 0) begin errors++; $display("FAIL fill_write w=%0d lat=%0d own=%0d oth=%0d want 1 1 0", w, lat, own, oth); end
        end
    endtask

    task automatic test_directed();
        int lat, own, oth, ces;
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, lat, own, oth, ces); ref_mem[4] = 32'hDEADBEEF;
        xact(1'b0, 32'h10, '0, 4'h0, 1'b0, lat, own, oth, ces);
        exp_irdt = 32'hDEADBEEF;
        checks++; if (lat != 2 || own != 1 || oth != 0 || ces != 1) begin errors++; $display("FAIL ibus_read_timing lat=%0d own=%0d oth=%0d ces=%0d want 2 1 0 1", lat, own, oth, ces); end
        checks++; if (ibus_rdt !== 32'hDEADBEEF) begin errors++; $display("FAIL ibus_read_data got=%h want deadbeef", ibus_rdt); end
        xact(1'b1, 32'h8, 32'h11223344, 4'hF, 1'b1, lat, own, oth, ces); ref_mem[2] = 32'h11223344;
        checks++; if (lat != 1 || ces != 1) begin errors++; $display("FAIL full_write_timing lat=%0d ces=%0d want 1 1", lat, ces); end
        xact(1'b1, 32'h8, '0, 4'h0, 1'b0, lat, own, oth, ces);
        exp_drdt = 32'h11223344;
        checks++; if (lat != 2 || dbus_rdt !== 32'h11223344) begin errors++; $display("FAIL full_write_readback lat=%0d got=%h want 2 11223344", lat, dbus_rdt); end
        xact(1'b1, 32'h8, 32'hAABBCCDD, 4'hF, 1'b1, lat, own, oth, ces); ref_mem[2] = 32'hAABBCCDD;
        xact(1'b1, 32'h8, 32'h000000EE, 4'b0001, 1'b1, lat, own, oth, ces); ref_mem[2] = 32'hAABBCCEE;
        checks++; if (lat != 2 || own != 1 || ces != 2) begin errors++; $display("FAIL partial_write_timing lat=%0d own=%0d ces=%0d want 2 1 2", lat, own, ces); end
        checks++; if (dbus_rdt !== 32'h11223344) begin errors++; $display("FAIL rdt_hold_over_write got=%h want 11223344", dbus_rdt); end
        xact(1'b1, 32'h8, '0, 4'h0, 1'b0, lat, own, oth, ces);
        exp_drdt = 32'hAABBCCEE;
        checks++; if (dbus_rdt !== 32'hAABBCCEE) begin errors++; $display("FAIL partial_write_readback got=%h want aabbccee", dbus_rdt); end
        xact(1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, 1'b1, lat, own, oth, ces);
        checks++; if (lat != 1 || own != 1 || ces != 0) begin errors++; $display("FAIL sel0_write lat=%0d own=%0d ces=%0d want 1 1 0", lat, own, ces); end
        xact(1'b1, RAM_SIZE + 32'h4, 32'h5A5A0001, 4'hF, 1'b1, lat, own, oth, ces); ref_mem[1] = 32'h5A5A0001;
        xact(1'b0, 32'h4, '0, 4'h0, 1'b0, lat, own, oth, ces);
        exp_irdt = 32'h5A5A0001;
        checks++; if (ibus_rdt !== 32'h5A5A0001) begin errors++; $display("FAIL addr_wrap got=%h want 5a5a0001", ibus_rdt); end
        xact(1'b0, 32'h30, '0, 4'h0, 1'b0, lat, own, oth, ces);
        exp_irdt = ref_mem[12];
        checks++; if (ibus_rdt !== ref_mem[12]) begin errors++; $display("FAIL sel0_unchanged got=%h want %h", ibus_rdt, ref_mem[12]); end
    endtask

    task automatic test_random();
        int lat, own, oth, ces, elat, eces, w;
        bit dp, we;
        logic [31:0] adr, dat;
        logic [3:0] sel;
        for (int n = 0; n < 60; n++) begin
            dp = 1'($urandom % 2); adr = $urandom; dat = $urandom;
            we = dp ? 1'($urandom % 2) : 1'b0;
            case ($urandom % 4)
                0: sel = 4'hF;
                1: sel = 4'h0;
                default: sel = 4'($urandom);
            endcase
            w = widx(adr);
            xact(dp, adr, dat, sel, we, lat, own, oth, ces);
            if (!we) begin
                elat = 2; eces = 1;
                if (dp) exp_drdt = ref_mem[w]; else exp_irdt = ref_mem[w];
            end else begin
                elat = (sel == 4'hF || sel == 4'h0) ? 1 : 2;
                eces = (sel == 4'hF) ? 1 : (sel == 4'h0) ? 0 : 2;
                ref_mem[w] = merge(ref_mem[w], dat, sel);
            end
            checks++; if (lat != elat || own != 1 || oth != 0 || ces != eces) begin errors++; $display("FAIL rand_timing n=%0d lat=%0d own=%0d oth=%0d ces=%0d want %0d 1 0 %0d", n, lat, own, oth, ces, elat, eces); end
            checks++; if (ibus_rdt !== exp_irdt || dbus_rdt !== exp_drdt) begin errors++; $display("FAIL rand_rdt n=%0d i=%h d=%h want %h %h", n, ibus_rdt, dbus_rdt, exp_irdt, exp_drdt); end
        end
    endtask

    task automatic test_contention();
        int iw, dw, nacks, bad_order, overlap, bad_data;
        bit expect_dbus;
        iw = int'($urandom % WORDS); dw = int'($urandom % WORDS);
        nacks = 0; bad_order = 0; overlap = 0; bad_data = 0; expect_dbus = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        ibus_adr = iw * 4; ibus_cyc = 1'b1;
        dbus_adr = dw * 4; dbus_we = 1'b0; dbus_sel = 4'hF; dbus_cyc = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (ibus_ack && dbus_ack) overlap++;
            if (ibus_ack || dbus_ack) begin
                if (dbus_ack != expect_dbus) bad_order++;
                if (ibus_ack && ibus_rdt !== ref_mem[iw]) bad_data++;
                if (dbus_ack && dbus_rdt !== ref_mem[dw]) bad_data++;
                expect_dbus = ~expect_dbus;
                nacks++;
            end
        end
        ibus_cyc = 1'b0; dbus_cyc = 1'b0;
        repeat (5) @(negedge clk);
        exp_irdt = ref_mem[iw]; exp_drdt = ref_mem[dw];
        checks++; if (nacks != 10) begin errors++; $display("FAIL contention_count got=%0d want 10", nacks); end
        checks++; if (bad_order != 0 || overlap != 0) begin errors++; $display("FAIL contention_order bad=%0d overlap=%0d want 0 0", bad_order, overlap); end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL contention_data bad=%0d want 0", bad_data); end
    endtask

    task automatic test_reset_in_merge();
        int lat, own, oth, ces, stray;
        stray = 0;
        @(negedge clk);
        dbus_adr = 32'h1C; dbus_dat = ~ref_mem[7]; dbus_sel = 4'b0110; dbus_we = 1'b1; dbus_cyc = 1'b1;
        @(negedge clk);
        checks++; if (ram_ce !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL merge_drive ce=%b we=%b want 1 1", ram_ce, ram_we); end
        reset = 1'b1; dbus_cyc = 1'b0;
        #1;
        checks++; if (ram_ce !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL merge_reset_override ce=%b we=%b want 0 0", ram_ce, ram_we); end
        @(negedge clk);
        reset = 1'b0;
        checks++; if (ibus_rdt !== 32'h0 || dbus_rdt !== 32'h0 || ibus_ack !== 1'b0 || dbus_ack !== 1'b0) begin errors++; $display("FAIL merge_reset_outputs i=%h d=%h ia=%b da=%b want 0", ibus_rdt, dbus_rdt, ibus_ack, dbus_ack); end
        for (int k = 0; k < 3; k++) begin @(negedge clk); if (ibus_ack || dbus_ack) stray++; end
        checks++; if (stray != 0) begin errors++; $display("FAIL merge_abort_ack got=%0d want 0", stray); end
        xact(1'b1, 32'h1C, '0, 4'h0, 1'b0, lat, own, oth, ces);
        checks++; if (lat != 2 || dbus_rdt !== ref_mem[7]) begin errors++; $display("FAIL merge_abort_word lat=%0d got=%h want 2 %h", lat, dbus_rdt, ref_mem[7]); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_random();
        test_contention();
        test_reset_in_merge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
